hog_cell_sequencer: RTL

- Frame-level controller that feeds cell histograms into the HOG feature generator.
- Accepts cell bins from the cell-histogram stage over a valid/ready handshake and issues them one per slot in raster order, with a cell address and a forward address.
- Drives the generator's clear condition at frame start, paces input with a programmable idle gap, then counts block-feature outputs to detect frame completion or timeout.

---
 rtl/hog_pkg.sv | 34 +++
 rtl/hog_seq_timer.sv | 31 +++
 rtl/hog_cell_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hog_pkg.sv
// Shared definitions for the HOG cell sequencer.
// - hog_state_t : frame controller state encoding
// - N_CELLS / N_BLKS : cell and block counts for the default 40x20 grid
// - hog_n_cells / hog_n_blks : the same counts for any grid size
// - hog_cell_w : width of one cell histogram (9 bins of bin_w bits each)
package hog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } hog_state_t;

  localparam int unsigned CELLS_X_DFLT = 40;
  localparam int unsigned CELLS_Y_DFLT = 20;
  localparam int unsigned N_CELLS      = CELLS_X_DFLT * CELLS_Y_DFLT;
  localparam int unsigned N_BLKS       = (CELLS_X_DFLT - 1) * (CELLS_Y_DFLT - 1);

  function automatic int unsigned hog_n_cells(input int unsigned cx, input int unsigned cy);
    return cx * cy;
  endfunction

  function automatic int unsigned hog_n_blks(input int unsigned cx, input int unsigned cy);
    return (cx - 1) * (cy - 1);
  endfunction

  function automatic int unsigned hog_cell_w(input int unsigned bin_w);
    return 9 * bin_w;
  endfunction

endpackage

// File: rtl/hog_seq_timer.sv
// Loadable down-counter with an expire flag.
// - load/load_val : load the count (has priority over counting)
// - en            : decrement by one while the count is non-zero
// - expired       : count is zero
// A load of N with en held gives expired after N enabled cycles.
module hog_seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/hog_cell_sequencer.sv
// Frame-level controller feeding cell histograms to the HOG feature generator.
// - start/abort        : frame control pulses (abort has priority)
// - s_bin/s_valid/s_ready : cell histograms from the cell-histogram stage
// - m_bin/m_address/m_addr_fw/m_valid : one cell per issue slot, raster order;
//                        m_addr_fw = 0 acts as the generator's clear
// - fea_valid/blk_cnt  : block features counted to detect frame end
// - busy/done/err      : status; err is a sticky drain-timeout flag
module hog_cell_sequencer
  import hog_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BIN_W   = 32,
  parameter int unsigned CELLS_X = 40,
  parameter int unsigned CELLS_Y = 20,
  parameter int unsigned GAP     = 1,
  parameter int unsigned TMO     = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [hog_cell_w(BIN_W)-1:0]  s_bin,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [hog_cell_w(BIN_W)-1:0]  m_bin,
  output logic [ADDR_W-1:0]             m_address,
  output logic [ADDR_W-1:0]             m_addr_fw,
  output logic                          m_valid,
  input  logic                          fea_valid,
  output logic [ADDR_W:0]               blk_cnt,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned FRAME_CELLS = hog_n_cells(CELLS_X, CELLS_Y);
  localparam int unsigned FRAME_BLKS  = hog_n_blks(CELLS_X, CELLS_Y);
  localparam int unsigned TMO_W       = $clog2(TMO + 1);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO - 1);

  hog_state_t state, state_nx;
  logic [ADDR_W-1:0] cell_idx;
  logic hs, last_cell, blk_full, start_ok, tmo_hit;
  logic gap_exp, tmo_exp;

  // s_ready follows the state alone; an abort in the same cycle still
  // discards the cell, so the internal handshake is masked by abort.
  assign hs        = s_valid && s_ready && !abort;
  assign last_cell = (cell_idx == ADDR_W'(FRAME_CELLS - 1));
  assign blk_full  = (blk_cnt >= (ADDR_W + 1)'(FRAME_BLKS));
  assign start_ok  = (state == ST_IDLE) && start && !abort;
  assign tmo_hit   = (state == ST_DRAIN) && !blk_full && tmo_exp && !abort;

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_CLEAR;
      end
      ST_CLEAR: state_nx = ST_STREAM;
      ST_STREAM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (last_cell)    state_nx = ST_DRAIN;
          else if (GAP > 0) state_nx = ST_GAP;
        end
      end
      ST_GAP:   if (gap_exp) state_nx = ST_STREAM;
      ST_DRAIN: if (blk_full || tmo_exp) state_nx = ST_DONE;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cell_idx  <= '0;
      m_valid   <= 1'b0;
      m_bin     <= '0;
      m_address <= '0;
      m_addr_fw <= '0;
      blk_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      state   <= state_nx;
      m_valid <= hs;
      if (hs) begin
        m_bin     <= s_bin;
        m_address <= cell_idx;
        // Hold on the final cell so the index never leaves the frame.
        if (!last_cell) cell_idx <= cell_idx + 1'b1;
      end
      if ((state_nx == ST_IDLE) || (state_nx == ST_CLEAR)) begin
        m_addr_fw <= '0;
      end else if (hs) begin
        m_addr_fw <= cell_idx + 1'b1;
      end
      if (start_ok) begin
        cell_idx <= '0;
        blk_cnt  <= '0;
        err      <= 1'b0;
      end else begin
        if ((state != ST_IDLE) && fea_valid && (blk_cnt != '1)) blk_cnt <= blk_cnt + 1'b1;
        if (tmo_hit) err <= 1'b1;
      end
    end
  end

  hog_seq_timer #(.W(4)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (hs && !last_cell),
    .load_val (GAP_LOAD),
    .en       (state == ST_GAP),
    .expired  (gap_exp)
  );

  hog_seq_timer #(.W(TMO_W)) u_tmo_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (hs && last_cell),
    .load_val (TMO_LOAD),
    .en       (state == ST_DRAIN),
    .expired  (tmo_exp)
  );

endmodule
